// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential unsigned restoring divider. Each RUN cycle produces one quotient
//   bit by shift-subtract, so a division takes WIDTH cycles. A zero divisor
//   skips RUN and returns quotient = all ones, remainder = dividend and
//   div_by_zero = 1.
//
// Ports
//   clk          rising-edge system clock
//   reset_n      asynchronous active-low reset
//   start        launch request, sampled only in IDLE
//   OpA, OpB     dividend / divisor, captured on the accepting edge
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   busy         high while iterating
//   done         one-cycle completion pulse
//   div_by_zero  set with a zero-divisor result, cleared on the next accept
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    // ZDIV spaces the zero-divisor result so its done pulse lands one cycle
    // after the accepting edge, without ever raising busy.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZDIV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   t_s;
    logic [WIDTH:0]   diff_s;
    logic             borrow_s;

    // Ripple-borrow subtractor x - y; returns {borrow_out, difference}.
    // The borrow-out doubles as the "x < y" decision.
    function automatic logic [WIDTH+1:0] sub_borrow(input logic [WIDTH:0] x,
                                                    input logic [WIDTH:0] y);
        logic           b;
        logic [WIDTH:0] d;
        b = 1'b0;
        d = {(WIDTH+1){1'b0}};
        for (int i = 0; i <= WIDTH; i++) begin
            d[i] = x[i] ^ y[i] ^ b;
            b    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b);
        end
        return {b, d};
    endfunction

    // Next-state, datapath iteration and output register inputs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        count_d = count_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        t_s                = {p_q, a_q[WIDTH-1]};
        {borrow_s, diff_s} = sub_borrow(t_s, {1'b0, b_q});

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (OpB != {WIDTH{1'b0}}) begin
                        a_d     = OpA;
                        b_d     = OpB;
                        p_d     = {WIDTH{1'b0}};
                        count_d = {CW{1'b0}};
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        quo_d   = {WIDTH{1'b1}};
                        rem_d   = OpA;
                        dbz_d   = 1'b1;
                        state_d = ZDIV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Restore (keep T) when the subtraction borrows, else keep T-B.
                a_d     = {a_q[WIDTH-2:0], ~borrow_s};
                p_d     = borrow_s ? t_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    quo_d   = {a_q[WIDTH-2:0], ~borrow_s};
                    rem_d   = borrow_s ? t_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            ZDIV: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy/done are registered from the next state so they line up with it.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            p_q     <= {WIDTH{1'b0}};
            count_q <= {CW{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            count_q <= count_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] OpA;
    logic [7:0] OpB;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    logic [7:0] prev_q = 8'd0;
    logic [7:0] prev_r = 8'd0;

    seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .OpA         (OpA),
        .OpB         (OpB),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One division: start pulse across one edge, then wait (bounded) for done.
    // lat = edges from the accepting edge to the first sample with done high.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic z, output int lat,
                           output bit hold_ok, output bit hs_ok);
        @(negedge clk);
        OpA = a; OpB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; hold_ok = 1'b1; hs_ok = 1'b1;
        if (b != 8'd0 && (quotient != prev_q || remainder != prev_r)) hold_ok = 1'b0;
        if (b == 8'd0 && busy) hs_ok = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy && done) hs_ok = 1'b0;
            if (b == 8'd0 && busy) hs_ok = 1'b0;
            if (!done && b != 8'd0 && (quotient != prev_q || remainder != prev_r)) hold_ok = 1'b0;
        end
        if (!done) lat = -1;
        q = quotient; r = remainder; z = div_by_zero;
        prev_q = q; prev_r = r;
        @(posedge clk); #1;
        if (quotient != q || remainder != r || done) hold_ok = 1'b0;
    endtask

    initial begin
        logic [7:0] q, r, ea, eb, eq, er;
        logic       z, ez;
        int         lat, elat, t;
        bit         hold_ok, hs_ok, hold_all, inv_ok, seen;

        vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8};
        vecs[1]  = '{8'd5,   8'd0,   8'd255, 8'd5,   1'b1, 1};
        vecs[2]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 8};
        vecs[3]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
        vecs[4]  = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 8};
        vecs[5]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
        vecs[6]  = '{8'd0,   8'd9,   8'd0,   8'd0,   1'b0, 8};
        vecs[7]  = '{8'd77,  8'd8,   8'd9,   8'd5,   1'b0, 8};
        vecs[8]  = '{8'd100, 8'd6,   8'd16,  8'd4,   1'b0, 8};
        vecs[9]  = '{8'd255, 8'd0,   8'd255, 8'd255, 1'b1, 1};
        vecs[10] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 8};
        vecs[11] = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0, 8};

        reset_n = 1'b0; start = 1'b0; OpA = 8'd0; OpB = 8'd0;
        #12;
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dbz", div_by_zero, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].a, vecs[i].b, q, r, z, lat, hold_ok, hs_ok);
            check($sformatf("vec%0d quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d dbz", i), z, vecs[i].z);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d handshake", i), hs_ok, 1);
            check($sformatf("vec%0d hold", i), hold_ok, 1);
        end

        // Zero divisor, then 9/3: dbz clears at accept, results held until done.
        run_div(8'd5, 8'd0, q, r, z, lat, hold_ok, hs_ok);
        check("z5 dbz", z, 1);
        @(negedge clk);
        OpA = 8'd9; OpB = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept dbz cleared", div_by_zero, 0);
        check("accept quotient held", quotient, 255);
        check("accept remainder held", remainder, 5);
        check("accept busy", busy, 1);
        t = 0;
        while (!done && t < 20) begin @(posedge clk); #1; t++; end
        check("9/3 latency", t, 8);
        check("9/3 quotient", quotient, 3);
        check("9/3 remainder", remainder, 0);
        prev_q = quotient; prev_r = remainder;
        @(posedge clk); #1;

        // 100/6 with start pulses during RUN and on the done cycle.
        @(negedge clk);
        OpA = 8'd100; OpB = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        OpA = 8'd50; OpB = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 4;
        while (!done && t < 20) begin @(posedge clk); #1; t++; end
        check("ign latency", t, 8);
        check("ign quotient", quotient, 16);
        check("ign remainder", remainder, 4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done-cycle start busy", busy, 0);
        check("done-cycle start done", done, 0);
        @(posedge clk); #1;
        check("no relaunch busy", busy, 0);
        check("no relaunch quotient", quotient, 16);
        prev_q = 8'd16; prev_r = 8'd4;
        run_div(8'd50, 8'd5, q, r, z, lat, hold_ok, hs_ok);
        check("50/5 quotient", q, 10);
        check("50/5 remainder", r, 0);
        check("50/5 latency", lat, 8);

        // Reset mid-RUN (4th RUN cycle, between edges).
        @(negedge clk);
        OpA = 8'd200; OpB = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midreset quotient", quotient, 0);
        check("midreset remainder", remainder, 0);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset dbz", div_by_zero, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
        check("no done after reset", seen, 0);
        prev_q = 8'd0; prev_r = 8'd0;
        run_div(8'd77, 8'd8, q, r, z, lat, hold_ok, hs_ok);
        check("77/8 quotient", q, 9);
        check("77/8 remainder", r, 5);

        // Random sweep against an arithmetic model.
        hold_all = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ea = 8'($urandom_range(0, 255));
            eb = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (eb == 8'd0) begin
                eq = 8'hFF; er = ea; ez = 1'b1; elat = 1;
            end else begin
                eq = ea / eb; er = ea % eb; ez = 1'b0; elat = 8;
            end
            run_div(ea, eb, q, r, z, lat, hold_ok, hs_ok);
            if (eb != 8'd0) begin
                inv_ok = ((16'(q) * 16'(eb) + 16'(r)) == 16'(ea)) && (r < eb);
                check($sformatf("rnd%0d invariant %0d/%0d", i, ea, eb), inv_ok, 1);
            end
            check($sformatf("rnd%0d result %0d/%0d", i, ea, eb),
                  {q, r, 7'd0, z}, {eq, er, 7'd0, ez});
            check($sformatf("rnd%0d latency", i), lat, elat);
            check($sformatf("rnd%0d handshake", i), hs_ok, 1);
            if (!hold_ok) hold_all = 1'b0;
        end
        check("rnd hold", hold_all, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
